// File: rtl/tff_ctrl_pkg.sv
// Shared constants and FSM encoding for the TFF bank sequencing controller.
package tff_ctrl_pkg;

   localparam int DEF_WIDTH = 4;
   localparam int DEF_NREQ  = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      APPLY = 2'b01,
      ACK   = 2'b10
   } state_e;

endpackage

// File: rtl/tff_bank_ctrl_if.sv
// Requester-side handshake bundle: per-requester req level, flattened masks, ack pulses.
interface tff_bank_ctrl_if
   import tff_ctrl_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int NREQ  = DEF_NREQ
);
   logic [NREQ-1:0]       req;
   logic [NREQ*WIDTH-1:0] mask;
   logic [NREQ-1:0]       ack;

   modport master (output req, output mask, input ack);
   modport slave  (input req, input mask, output ack);
endinterface

// File: rtl/tff_bank_ctrl_cell.sv
// Single toggle cell: q flips on every rising edge where t is high.
module tff_cell (
   input  logic clk,
   input  logic re,
   input  logic t,
   output logic q
);
   logic q_q;

   always_ff @(posedge clk or negedge re) begin
      if (!re) q_q <= 1'b0;
      else     q_q <= q_q ^ t;
   end

   assign q = q_q;
endmodule

// File: rtl/tff_bank_ctrl.sv
// Round-robin sequencer that applies one requester's toggle mask to a TFF bank per transaction.
// Optional registered parity output is enabled by defining TFF_CTRL_PARITY_EN.
module tff_bank_ctrl
   import tff_ctrl_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int NREQ  = DEF_NREQ
)(
   input  logic                    clk,
   input  logic                    re,
   tff_bank_ctrl_if.slave          bus,
   output logic [WIDTH-1:0]        q,
   output logic                    busy,
   output logic [$clog2(NREQ)-1:0] grant_id
`ifdef TFF_CTRL_PARITY_EN
   ,
   output logic                    parity
`endif
);
   localparam int GW = $clog2(NREQ);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] mask_q, mask_d;
   logic [GW-1:0]    ptr_q, ptr_d;
   logic [GW-1:0]    grant_q, grant_d;
   logic [NREQ-1:0]  ack_q, ack_d;
   logic             busy_q, busy_d;
   logic [WIDTH-1:0] t;

   logic             win_vld;
   logic [GW-1:0]    win_id;
   int               idx;

   // Round-robin search starting one past the last winner.
   always_comb begin
      win_vld = 1'b0;
      win_id  = '0;
      idx     = 0;
      for (int k = 1; k <= NREQ; k++) begin
         idx = (int'(ptr_q) + k) % NREQ;
         if (!win_vld && bus.req[idx]) begin
            win_vld = 1'b1;
            win_id  = GW'(idx);
         end
      end
   end

   always_comb begin
      state_d = state_q;
      mask_d  = mask_q;
      ptr_d   = ptr_q;
      grant_d = grant_q;
      ack_d   = '0;
      busy_d  = busy_q;
      case (state_q)
         IDLE: begin
            if (win_vld) begin
               state_d = APPLY;
               grant_d = win_id;
               mask_d  = bus.mask[win_id*WIDTH +: WIDTH];
               busy_d  = 1'b1;
            end
         end
         APPLY: begin
            state_d        = ACK;
            ack_d[grant_q] = 1'b1;
         end
         ACK: begin
            state_d = IDLE;
            ptr_d   = grant_q;
            busy_d  = 1'b0;
         end
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge re) begin
      if (!re) begin
         state_q <= IDLE;
         mask_q  <= '0;
         ptr_q   <= GW'(NREQ-1);
         grant_q <= '0;
         ack_q   <= '0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         mask_q  <= mask_d;
         ptr_q   <= ptr_d;
         grant_q <= grant_d;
         ack_q   <= ack_d;
         busy_q  <= busy_d;
      end
   end

   // The bank only sees the latched mask for the single APPLY cycle.
   assign t = (state_q == APPLY) ? mask_q : '0;

   for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      tff_cell u_cell (
         .clk (clk),
         .re  (re),
         .t   (t[i]),
         .q   (q[i])
      );
   end

`ifdef TFF_CTRL_PARITY_EN
   logic parity_q, parity_d;

   // Predict the next bank state so parity updates on the same edge as q.
   assign parity_d = ^(q ^ t);

   always_ff @(posedge clk or negedge re) begin
      if (!re) parity_q <= 1'b0;
      else     parity_q <= parity_d;
   end

   assign parity = parity_q;
`endif

   assign bus.ack  = ack_q;
   assign busy     = busy_q;
   assign grant_id = grant_q;
endmodule

// File: doc/tff_bank_ctrl.md
# tff_bank_ctrl

Sequencing and arbitration controller for a shared bank of toggle flip-flops. Up to NREQ requesters each submit a WIDTH-bit toggle mask through a req/ack handshake. A round-robin arbiter selects one request at a time and drives the mask onto the bank's t inputs for exactly one clock, so that q ^= mask. The block sits between software-visible request sources and the TFF bank, and it owns the bank's state output.

## Interface
- WIDTH, 4: number of toggle flip-flops in the bank.
- NREQ, 4: number of requesters (≥2).
- clk  input  1  single clock; all state changes on rising edge.
- re  input  1  reset, asynchronous, active-low; clears all state immediately.
- req  input  NREQ  per-requester request level; held high until matching ack.
- mask  input  NREQ*WIDTH  flattened toggle masks; requester i at bits [i*WIDTH +: WIDTH]; stable while req[i] high.
- ack  output  NREQ  one-cycle pulse to the serviced requester after its toggle is applied.
- q  output  WIDTH  current bank state.
- busy  output  1  high in APPLY and ACK.
- grant_id  output  $clog2(NREQ)  index of the current or most recent winner.
- parity  output  1  XOR-reduction of q; present only with TFF_CTRL_PARITY_EN.

## Operation
- FSM states:
  - IDLE: waits for any req bit.
  - APPLY: drives the bank's t inputs from the latched mask.
  - ACK: pulses ack for the winner.
- IDLE→APPLY when |req. On that edge:
  - Latch the winner index into grant_id.
  - Latch mask[winner] into a WIDTH-bit register.
- APPLY→ACK unconditionally. The bank's t equals the latched mask during APPLY only; t=0 in all other states.
- ACK→IDLE unconditionally.
  - ack[grant_id]=1 for the whole ACK cycle; all other ack bits 0.
  - The priority pointer is set to grant_id on this edge.
- Arbitration is round-robin: search starts at pointer+1 and wraps modulo NREQ. The first set req bit wins.
- Requester rules:
  - A requester must deassert req in the cycle following its ack.
  - A req still high in that IDLE cycle is treated as a new request.
- A zero mask is serviced normally: q is unchanged and ack is still issued.
- The mask is sampled only at IDLE→APPLY. Later changes to mask, or a req dropped early, do not affect the in-flight toggle. If req drops early, ack is still pulsed.
- Reset (re=0), at any time including mid-APPLY or mid-ACK:
  - Outputs: q=0, ack=0, busy=0, grant_id=0.
  - Internal: FSM=IDLE, latched mask=0, pointer=NREQ-1 (so requester 0 has first priority).
  - An in-flight transaction is dropped with no ack.

## Timing
- Cycle 0: FSM in IDLE, req[i] rises.
- Edge 1: FSM enters APPLY; busy=1; grant_id=i.
- Edge 2: q becomes q^mask; FSM enters ACK; ack[i]=1.
- Edge 3: FSM returns to IDLE; ack=0; busy=0.
- Throughput: one toggle per 3 cycles under continuous demand.
- All outputs are registered; there are no combinational paths from req or mask to any output.

## Configuration
- TFF_CTRL_PARITY_EN defined:
  - The parity output exists and is registered alongside q.
  - parity always equals ^q; it is 0 during and after reset.
- Undefined: the parity port and its logic are absent. All other behaviour is identical.

## Structure
- Package tff_ctrl_pkg contains:
  - The state encoding, IDLE=2'b00, APPLY=2'b01, ACK=2'b10; other codes recover to IDLE.
  - Default WIDTH and NREQ constants.
- Sub-module tff_cell (clk, re, t, q) is a single D-flop toggle cell: q<=q^t, with async active-low clear. It is instantiated WIDTH times via generate.
- The arbiter pointer logic stays inline in tff_bank_ctrl.

## Test plan
Unless stated otherwise, WIDTH=4 and NREQ=4.
- Reset: hold re=0 → q=0000, ack=0000, busy=0, grant_id=0. Release re → FSM stays in IDLE with no activity.
- Single request: req=0001, mask0=0101 → q=0101 at edge 2, ack=0001 for one cycle. Repeat the request → q=0000.
- Full contention: req=1111 with masks 0001/0010/0100/1000, each requester dropping req after its ack → grants in order 0,1,2,3; q=1111 after 12 cycles.
- Fairness: req[0] and req[2] re-request immediately after each IDLE → grant_id alternates 0,2,0,2. Requesters 1 and 3 are never granted.
- Reset mid-APPLY: re pulsed low during APPLY for requester 1 → q=0000 and no ack. After release, req[1] still high → requester 1 is serviced with grant_id=1.
- Parity (macro defined): apply mask 0111 → parity=1 from edge 2. Then apply mask 0001 → q=0110, parity=0. Build without the macro → the port is absent and q behaves identically.
